// File: rtl/pipe_id_branch_pkg.sv
// Shared pipeline definitions: MIPS opcode/funct values, next-PC select codes,
// ID-stage branch FSM states and branch-target helpers used by ID and the IF next-PC mux.
package pipe_id_branch_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  typedef enum logic [1:0] {
    PCSRC_PC4    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JREG   = 2'b10,
    PCSRC_JUMP   = 2'b11
  } pc_src_t;

  typedef enum logic {
    RUN       = 1'b0,
    WAIT_OPND = 1'b1
  } id_state_t;

  typedef enum logic [2:0] {
    CLS_OTHER = 3'd0,
    CLS_BEQ   = 3'd1,
    CLS_BNE   = 3'd2,
    CLS_J     = 3'd3,
    CLS_JAL   = 3'd4,
    CLS_JR    = 3'd5,
    CLS_JALR  = 3'd6
  } br_class_t;

  typedef struct packed {
    br_class_t cls;
    logic      need_rs;
    logic      need_rt;
    logic      link;
  } br_dec_t;

  // Conditional branch target: pc4 plus the word-scaled, sign-extended offset.
  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [15:0] imm);
    return pc4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // Absolute jump target inside the current 256 MB region.
  function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                              input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

endpackage

// File: rtl/pipe_id_branch_if.sv
// IF/ID-stage branch resolution bus: fetch and operand inputs, redirect and
// IF/ID register outputs. slave is the ID branch unit, master is its environment.
interface pipe_id_branch_if;

  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rs_rdy;
  logic        rt_rdy;
  logic        ext_stall;

  logic [1:0]  pc_source;
  logic [31:0] condit_bran_pc;
  logic [31:0] j_reg_pc;
  logic [31:0] j_pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        stall_if;
  logic        link_we;
  logic [31:0] link_addr;

  modport master (
    output if_inst, if_pc4, rs_val, rt_val, rs_rdy, rt_rdy, ext_stall,
    input  pc_source, condit_bran_pc, j_reg_pc, j_pc, id_inst, id_pc4,
           stall_if, link_we, link_addr
  );

  modport slave (
    input  if_inst, if_pc4, rs_val, rt_val, rs_rdy, rt_rdy, ext_stall,
    output pc_source, condit_bran_pc, j_reg_pc, j_pc, id_inst, id_pc4,
           stall_if, link_we, link_addr
  );

endinterface

// File: rtl/id_branch_decode.sv
// Combinational decode of the ID instruction into a control-transfer class,
// the register operands that class depends on, and whether it writes a link.
module id_branch_decode
  import pipe_id_branch_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output br_dec_t    dec
);

  always_comb begin
    dec = '{cls: CLS_OTHER, need_rs: 1'b0, need_rt: 1'b0, link: 1'b0};
    unique case (op)
      OP_BEQ: dec = '{cls: CLS_BEQ, need_rs: 1'b1, need_rt: 1'b1, link: 1'b0};
      OP_BNE: dec = '{cls: CLS_BNE, need_rs: 1'b1, need_rt: 1'b1, link: 1'b0};
      OP_J:   dec = '{cls: CLS_J,   need_rs: 1'b0, need_rt: 1'b0, link: 1'b0};
      OP_JAL: dec = '{cls: CLS_JAL, need_rs: 1'b0, need_rt: 1'b0, link: 1'b1};
      OP_SPECIAL: begin
        if (funct == FN_JR) begin
          dec = '{cls: CLS_JR, need_rs: 1'b1, need_rt: 1'b0, link: 1'b0};
        end else if (funct == FN_JALR) begin
          dec = '{cls: CLS_JALR, need_rs: 1'b1, need_rt: 1'b0, link: 1'b1};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_id_branch.sv
// ID-stage branch unit: holds IF/ID, resolves branches/jumps with zero latency once
// operands are ready, stalls IF while operands are in flight or downstream holds.
module pipe_id_branch
  import pipe_id_branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC4 = 32'h0000_0004,
  parameter logic [31:0] NOP_INST  = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             resetn,
  pipe_id_branch_if.slave  bus
);

  logic [31:0] id_inst_q;
  logic [31:0] id_pc4_q;
  id_state_t   state_q;
  id_state_t   state_d;
  br_dec_t     dec;
  logic        opnd_ok;
  logic        resolve;
  logic        stall;
  logic        link;
  pc_src_t     pc_src;

  id_branch_decode u_decode (
    .op    (id_inst_q[31:26]),
    .funct (id_inst_q[5:0]),
    .dec   (dec)
  );

  assign opnd_ok = (!dec.need_rs || bus.rs_rdy) && (!dec.need_rt || bus.rt_rdy);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ext_stall freezes the FSM: resolution is simply retried once it drops.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (!bus.ext_stall && !opnd_ok) begin
          state_d = WAIT_OPND;
        end
      end
      WAIT_OPND: begin
        if (!bus.ext_stall && opnd_ok) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall   = bus.ext_stall || !opnd_ok;
    resolve = opnd_ok && !bus.ext_stall;
    pc_src  = PCSRC_PC4;
    link    = 1'b0;
    if (resolve) begin
      link = dec.link;
      unique case (dec.cls)
        CLS_BEQ:          pc_src = (bus.rs_val == bus.rt_val) ? PCSRC_BRANCH : PCSRC_PC4;
        CLS_BNE:          pc_src = (bus.rs_val != bus.rt_val) ? PCSRC_BRANCH : PCSRC_PC4;
        CLS_J, CLS_JAL:   pc_src = PCSRC_JUMP;
        CLS_JR, CLS_JALR: pc_src = PCSRC_JREG;
        default:          pc_src = PCSRC_PC4;
      endcase
    end
  end

  // The delay slot loads in the resolving cycle; redirect affects the fetch after it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      id_inst_q <= NOP_INST;
      id_pc4_q  <= RESET_PC4;
    end else if (!stall) begin
      id_inst_q <= bus.if_inst;
      id_pc4_q  <= bus.if_pc4;
    end
  end

  assign bus.pc_source      = pc_src;
  assign bus.stall_if       = stall;
  assign bus.link_we        = link;
  assign bus.link_addr      = id_pc4_q + 32'd4;
  assign bus.condit_bran_pc = branch_target(id_pc4_q, id_inst_q[15:0]);
  assign bus.j_pc           = jump_target(id_pc4_q[31:28], id_inst_q[25:0]);
  assign bus.j_reg_pc       = bus.rs_val;
  assign bus.id_inst        = id_inst_q;
  assign bus.id_pc4         = id_pc4_q;

endmodule

// File: tb/tb_pipe_id_branch.sv
// Bench for pipe_id_branch: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an instruction-level model.
module tb_pipe_id_branch;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] RPC4 = 32'h0000_0004;

  typedef struct {
    logic        stall;
    logic [1:0]  src;
    logic        link;
    logic [31:0] cb;
    logic [31:0] jr;
    logic [31:0] jp;
    logic [31:0] la;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  pipe_id_branch_if bus();

  pipe_id_branch #(.RESET_PC4(RPC4), .NOP_INST(NOP)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int   checks   = 0;
  int   failures = 0;
  bit   cmp_en   = 1'b0;
  logic [31:0] m_inst;
  logic [31:0] m_pc4;

  // What the ID stage must do for the instruction the model believes is in IF/ID.
  function automatic exp_t model();
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    bit beq, bne, j, jal, jr, jalr, rdy, go;
    logic signed [31:0] off;
    op   = m_inst[31:26];
    fn   = m_inst[5:0];
    beq  = (op == 6'd4);
    bne  = (op == 6'd5);
    j    = (op == 6'd2);
    jal  = (op == 6'd3);
    jr   = (op == 6'd0) && (fn == 6'd8);
    jalr = (op == 6'd0) && (fn == 6'd9);
    rdy  = 1'b1;
    if ((beq || bne || jr || jalr) && !bus.rs_rdy) rdy = 1'b0;
    if ((beq || bne) && !bus.rt_rdy) rdy = 1'b0;
    go      = rdy && !bus.ext_stall;
    e.stall = !go;
    e.src   = 2'd0;
    if (go) begin
      if (beq && bus.rs_val == bus.rt_val) e.src = 2'd1;
      if (bne && bus.rs_val != bus.rt_val) e.src = 2'd1;
      if (j || jal)   e.src = 2'd3;
      if (jr || jalr) e.src = 2'd2;
    end
    e.link = go && (jal || jalr);
    off    = 32'(signed'(m_inst[15:0]));
    e.cb   = m_pc4 + 32'(off * 4);
    e.jr   = bus.rs_val;
    e.jp   = (m_pc4 & 32'hF000_0000) | ((m_inst & 32'h03FF_FFFF) << 2);
    e.la   = m_pc4 + 32'd4;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always begin : compare
    exp_t e;
    @(negedge clk);
    #1;
    if (cmp_en) begin
      e = model();
      chk("stall_if",  {31'd0, bus.stall_if}, {31'd0, e.stall});
      chk("pc_source", {30'd0, bus.pc_source}, {30'd0, e.src});
      chk("link_we",   {31'd0, bus.link_we}, {31'd0, e.link});
      chk("id_inst",   bus.id_inst, m_inst);
      chk("id_pc4",    bus.id_pc4, m_pc4);
      if (e.src == 2'd1) chk("condit_bran_pc", bus.condit_bran_pc, e.cb);
      if (e.src == 2'd2) chk("j_reg_pc", bus.j_reg_pc, e.jr);
      if (e.src == 2'd3) chk("j_pc", bus.j_pc, e.jp);
      if (e.link)        chk("link_addr", bus.link_addr, e.la);
    end
  end

  always @(posedge clk) begin : model_update
    exp_t e;
    e = model();
    if (!resetn) begin
      m_inst <= NOP;
      m_pc4  <= RPC4;
    end else if (!e.stall) begin
      m_inst <= bus.if_inst;
      m_pc4  <= bus.if_pc4;
    end
  end

  task automatic step(input logic [31:0] inst, input logic [31:0] pc4,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic rsr, input logic rtr, input logic ext, input logic rst);
    @(negedge clk);
    bus.if_inst   = inst;
    bus.if_pc4    = pc4;
    bus.rs_val    = rs;
    bus.rt_val    = rt;
    bus.rs_rdy    = rsr;
    bus.rt_rdy    = rtr;
    bus.ext_stall = ext;
    resetn        = rst;
    #2;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return {6'b000100, r[25:0]};
      1: return {6'b000101, r[25:0]};
      2: return {6'b000010, r[25:0]};
      3: return {6'b000011, r[25:0]};
      4: return {6'b000000, r[25:21], 15'd0, 6'b001000};
      5: return {6'b000000, r[25:21], 5'd0, 5'd31, 5'd0, 6'b001001};
      6: return r;
      default: return NOP;
    endcase
  endfunction

  localparam logic [31:0] I_BEQ = 32'h1022_FFFE;
  localparam logic [31:0] I_BNE = 32'h1422_0003;
  localparam logic [31:0] I_JR  = 32'h0060_0008;
  localparam logic [31:0] I_JAL = 32'h0C00_0040;
  localparam logic [31:0] I_J   = 32'h0800_0010;

  initial begin
    resetn        = 1'b0;
    bus.if_inst   = NOP;
    bus.if_pc4    = 32'd0;
    bus.rs_val    = 32'd0;
    bus.rt_val    = 32'd0;
    bus.rs_rdy    = 1'b0;
    bus.rt_rdy    = 1'b0;
    bus.ext_stall = 1'b0;

    step(NOP, 32'h0, 0, 0, 1, 1, 0, 0);
    cmp_en = 1'b1;
    step(I_BEQ, 32'h100, 0, 0, 1, 1, 0, 1);
    chk("rst_id_inst",  bus.id_inst, NOP);
    chk("rst_id_pc4",   bus.id_pc4, RPC4);
    chk("rst_stall_if", {31'd0, bus.stall_if}, 32'd0);
    chk("rst_pc_src",   {30'd0, bus.pc_source}, 32'd0);
    chk("rst_link_we",  {31'd0, bus.link_we}, 32'd0);

    step(I_BNE, 32'h200, 5, 5, 1, 1, 0, 1);
    chk("beq_pc_src", {30'd0, bus.pc_source}, 32'd1);
    chk("beq_target", bus.condit_bran_pc, 32'h0000_00F8);

    step(I_JR, 32'h300, 7, 7, 1, 1, 0, 1);
    chk("bne_pc_src", {30'd0, bus.pc_source}, 32'd0);
    chk("bne_stall",  {31'd0, bus.stall_if}, 32'd0);

    for (int k = 0; k < 2; k++) begin
      step(NOP, 32'h304, 0, 0, 0, 1, 0, 1);
      chk("jr_wait_stall",  {31'd0, bus.stall_if}, 32'd1);
      chk("jr_wait_pc_src", {30'd0, bus.pc_source}, 32'd0);
    end
    step(I_JAL, 32'h9000_0010, 32'h400, 0, 1, 0, 0, 1);
    chk("jr_pc_src", {30'd0, bus.pc_source}, 32'd2);
    chk("jr_target", bus.j_reg_pc, 32'h0000_0400);
    chk("jr_stall",  {31'd0, bus.stall_if}, 32'd0);

    step(I_JR, 32'h500, 0, 0, 1, 1, 0, 1);
    chk("jr_advanced",   bus.id_inst, I_JAL);
    chk("jal_pc_src",    {30'd0, bus.pc_source}, 32'd3);
    chk("jal_target",    bus.j_pc, 32'h9000_0100);
    chk("jal_link_we",   {31'd0, bus.link_we}, 32'd1);
    chk("jal_link_addr", bus.link_addr, 32'h9000_0014);

    step(NOP, 32'h504, 0, 0, 0, 0, 0, 1);
    chk("jr2_stall", {31'd0, bus.stall_if}, 32'd1);
    step(NOP, 32'h504, 0, 0, 0, 0, 0, 0);
    step(I_J, 32'h600, 0, 0, 0, 0, 0, 1);
    chk("abandon_id_inst", bus.id_inst, NOP);
    chk("abandon_id_pc4",  bus.id_pc4, RPC4);
    chk("abandon_pc_src",  {30'd0, bus.pc_source}, 32'd0);
    chk("abandon_stall",   {31'd0, bus.stall_if}, 32'd0);

    for (int k = 0; k < 3; k++) begin
      step(NOP, 32'h700, 0, 0, 1, 1, 1, 1);
      chk("ext_pc_src",  {30'd0, bus.pc_source}, 32'd0);
      chk("ext_stall",   {31'd0, bus.stall_if}, 32'd1);
      chk("ext_id_inst", bus.id_inst, I_J);
    end
    step(NOP, 32'h700, 0, 0, 1, 1, 0, 1);
    chk("j_pc_src", {30'd0, bus.pc_source}, 32'd3);
    chk("j_target", bus.j_pc, 32'h0000_0040);

    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rs, rt;
      rs = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
      rt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
      step(rand_inst(), $urandom, rs, rt,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 99) != 0);
    end

    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_id_branch.md
PIPE_ID_BRANCH -- requirements
Module: pipe_id_branch

Interface
REQ-001 SHALL have parameter RESET_PC4, default 32'h0000_0004, the IF/ID pc4 value loaded at reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0000, the instruction word injected as a bubble.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 if_inst  in  32  fetched instruction from IF.
REQ-006 if_pc4  in  32  pc+4 of the fetched instruction.
REQ-007 rs_val, rt_val  in  32 each  forwarded register operands for the instruction in ID.
REQ-008 rs_rdy, rt_rdy  in  1 each  operand valid; low means a producer is still in flight.
REQ-009 ext_stall  in  1  hold from downstream; freezes IF/ID.
REQ-010 pc_source  out  2  next-PC select: 00 pc4, 01 condit_bran_pc, 10 j_reg_pc, 11 j_pc.
REQ-011 condit_bran_pc, j_reg_pc, j_pc  out  32 each  redirect targets.
REQ-012 id_inst, id_pc4  out  32 each  IF/ID register contents.
REQ-013 stall_if  out  1  high to hold PC and IF/ID.
REQ-014 link_we  out  1, link_addr  out  32  JAL/JALR return-address write (pc of branch + 8).

Function
REQ-015 Decode SHALL use MIPS encodings: BEQ op 000100, BNE 000101, J 000010, JAL 000011, JR op 000000 funct 001000, JALR op 000000 funct 001001.
REQ-016 condit_bran_pc SHALL equal id_pc4 + (sign-extended imm16 << 2), modulo 2^32.
REQ-017 j_pc SHALL equal {id_pc4[31:28], inst[25:0], 2'b00}; j_reg_pc SHALL equal rs_val.
REQ-018 Targets SHALL be combinational from IF/ID contents and operands, valid whenever pc_source is nonzero.
REQ-019 FSM states: RUN, WAIT_OPND.
REQ-020 In RUN: BEQ/BNE, JR and JALR need rs_rdy (BEQ/BNE also need rt_rdy); if a needed operand is not ready, go to WAIT_OPND, assert stall_if, and drive pc_source 00.
REQ-021 In WAIT_OPND: stay and keep stall_if high until all needed operands are ready; in the ready cycle resolve as in RUN and return to RUN.
REQ-022 Resolution: BEQ taken if rs_val==rt_val; BNE taken if not equal; taken gives pc_source 01, else 00. J and JAL give 11. JR and JALR give 10. Any other instruction gives 00.
REQ-023 pc_source SHALL be nonzero for exactly one cycle per ID instruction, the resolving cycle, with zero-cycle latency from ready operands.
REQ-024 Redirect applies to the delay slot next: IF/ID SHALL load normally in the resolving cycle, with no flush.
REQ-025 link_we SHALL be high for one cycle in the resolving cycle of JAL/JALR; link_addr = id_pc4 + 4.
REQ-026 IF/ID SHALL load if_inst/if_pc4 when stall_if=0 and ext_stall=0, and hold otherwise.
REQ-027 If ext_stall is high in a resolving cycle: pc_source, link_we = 0; the FSM holds state; resolution is re-evaluated when ext_stall falls. ext_stall takes precedence.
REQ-028 stall_if SHALL be high whenever ext_stall is high.

Reset
REQ-029 With resetn low at a clock edge: IF/ID = NOP_INST/RESET_PC4; FSM = RUN; hence pc_source=00, stall_if=0, link_we=0.
REQ-030 Reset during WAIT_OPND SHALL abandon the pending branch with no redirect.

Structure
REQ-031 Opcode/funct constants, pc_source encodings and FSM state encodings SHALL live in the shared pipeline package, also used by the IF next-PC mux.
REQ-032 One sub-module is natural: id_branch_decode, combinational decode giving the instruction class and needed operands.

Verification
REQ-033 BEQ imm=16'hFFFE, id_pc4=0x100, rs=rt=5, both ready -> same cycle pc_source=01, condit_bran_pc=0x0F8.
REQ-034 BNE, rs=rt=7 -> pc_source=00, no stall.
REQ-035 JR with rs_rdy low for 2 cycles, then rs_val=0x400 -> stall_if high 2 cycles, then pc_source=10 and j_reg_pc=0x400 for one cycle, IF/ID advances.
REQ-036 JAL inst[25:0]=0x0000040, id_pc4=0x9000_0010 -> pc_source=11, j_pc=0x9000_0100, link_we=1, link_addr=0x9000_0014.
REQ-037 JR waiting, then resetn low -> next cycle: FSM RUN, id_inst=NOP_INST, pc_source=00, stall_if=0.
REQ-038 J with ext_stall high 3 cycles -> pc_source=00 while stalled, then 11 for one cycle after release.
